// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg: shared fetch FSM states, length type and opcode lengths.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  typedef logic [1:0] instr_len_t;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0200;

  // Total instruction length in bytes (opcode plus operands) for a 6502 opcode.
  function automatic instr_len_t instr_length(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    logic [2:0] aaa;
    instr_len_t len;
    cc  = op[1:0];
    bbb = op[4:2];
    aaa = op[7:5];
    len = 2'd1;
    case (cc)
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
        else                                                  len = 2'd2;
      end
      2'b10: begin
        case (bbb)
          3'b011, 3'b111:         len = 2'd3;
          3'b000, 3'b001, 3'b101: len = 2'd2;
          default:                len = 2'd1;
        endcase
      end
      2'b00: begin
        if (op == 8'h20)                                   len = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
        else begin
          case (bbb)
            3'b100:         len = 2'd2;
            3'b000:         len = (aaa >= 3'b101) ? 2'd2 : 2'd1;
            3'b001, 3'b101: len = 2'd2;
            3'b011, 3'b111: len = 2'd3;
            default:        len = 2'd1;
          endcase
        end
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_len_lut.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_len_lut: combinational opcode -> instruction length.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_len_lut
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output instr_len_t len
);

  always_comb begin
    len = instr_length(opcode);
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit: 6502 PC owner, fetches opcode+operands, valid/ready.   |
// | Optional macro FETCH_SYNC_EN adds the SYNC output. Rev 1.0         |
// +--------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        pc_load,
  input  logic [15:0] pc_new,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc
`ifdef FETCH_SYNC_EN
  ,
  output logic        sync
`endif
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [7:0]   operand_lo_q, operand_lo_d;
  logic [7:0]   operand_hi_q, operand_hi_d;
  instr_len_t   instr_len_q, instr_len_d;
  logic [15:0]  instr_pc_q, instr_pc_d;
  instr_len_t   fetch_len;

  fetch_len_lut u_len_lut (
    .opcode (mem_data),
    .len    (fetch_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_OP;
      pc_q         <= RESET_PC;
      opcode_q     <= 8'h00;
      operand_lo_q <= 8'h00;
      operand_hi_q <= 8'h00;
      instr_len_q  <= 2'd1;
      instr_pc_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      opcode_q     <= opcode_d;
      operand_lo_q <= operand_lo_d;
      operand_hi_q <= operand_hi_d;
      instr_len_q  <= instr_len_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // A redirect abandons any capture in flight; bundle registers simply go stale.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opcode_d     = opcode_q;
    operand_lo_d = operand_lo_q;
    operand_hi_d = operand_hi_q;
    instr_len_d  = instr_len_q;
    instr_pc_d   = instr_pc_q;
    if (pc_load) begin
      state_d = FETCH_OP;
      pc_d    = pc_new;
    end else begin
      case (state_q)
        FETCH_OP: begin
          opcode_d     = mem_data;
          instr_pc_d   = pc_q;
          operand_lo_d = 8'h00;
          operand_hi_d = 8'h00;
          instr_len_d  = fetch_len;
          pc_d         = pc_q + 16'd1;
          state_d      = (fetch_len == 2'd1) ? HOLD : FETCH_LO;
        end
        FETCH_LO: begin
          operand_lo_d = mem_data;
          pc_d         = pc_q + 16'd1;
          state_d      = (instr_len_q == 2'd2) ? HOLD : FETCH_HI;
        end
        FETCH_HI: begin
          operand_hi_d = mem_data;
          pc_d         = pc_q + 16'd1;
          state_d      = HOLD;
        end
        HOLD: begin
          if (instr_ready) state_d = FETCH_OP;
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    mem_rd      = (state_q != HOLD);
    instr_valid = (state_q == HOLD);
`ifdef FETCH_SYNC_EN
    sync        = (state_q == FETCH_OP) && !rst;
`endif
  end

  assign mem_addr   = pc_q;
  assign opcode     = opcode_q;
  assign operand_lo = operand_lo_q;
  assign operand_hi = operand_hi_q;
  assign instr_len  = instr_len_q;
  assign instr_pc   = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit: directed self-checking bench for fetch_unit.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
`ifdef FETCH_SYNC_EN
  logic        sync;
`endif

  logic [7:0] mem [0:65535];
  int errors = 0;
  int checks = 0;

  assign mem_data = mem[mem_addr];

  fetch_unit #(.RESET_PC(16'h0200)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand_lo  (operand_lo),
    .operand_hi  (operand_hi),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc)
`ifdef FETCH_SYNC_EN
    ,
    .sync        (sync)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for instr_valid; returns the number of cycles spent.
  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  typedef struct { logic [7:0] op; int len; } len_vec_t;
  len_vec_t lv[20] = '{
    '{8'hEA,1}, '{8'hA9,2}, '{8'h8D,3}, '{8'h4C,3}, '{8'h20,3},
    '{8'h10,2}, '{8'hA0,2}, '{8'h80,1}, '{8'h24,2}, '{8'h6C,3},
    '{8'h8A,1}, '{8'hA2,2}, '{8'h9E,3}, '{8'h0B,1}, '{8'h96,2},
    '{8'h19,3}, '{8'h01,2}, '{8'h60,1}, '{8'h18,1}, '{8'hBC,3}
  };

  int n1, n2;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    rst = 1'b1; pc_load = 1'b0; pc_new = 16'h0000; instr_ready = 1'b0;

    // Reset and single-byte NOP
    tick(); tick();
    check("rst_valid",   32'(instr_valid), 0);
    check("rst_addr",    32'(mem_addr), 'h0200);
    check("rst_opcode",  32'(opcode), 0);
    check("rst_len",     32'(instr_len), 1);
    check("rst_ipc",     32'(instr_pc), 0);
    check("rst_mem_rd",  32'(mem_rd), 1);
    rst = 1'b0;
    tick();
    check("nop_valid",   32'(instr_valid), 1);
    check("nop_opcode",  32'(opcode), 'hEA);
    check("nop_len",     32'(instr_len), 1);
    check("nop_ipc",     32'(instr_pc), 'h0200);
    check("nop_lo",      32'(operand_lo), 0);
    check("nop_hi",      32'(operand_hi), 0);
    check("nop_next",    32'(mem_addr), 'h0201);

    // Stall in HOLD
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",  32'(instr_valid), 1);
      check("stall_opcode", 32'(opcode), 'hEA);
      check("stall_addr",   32'(mem_addr), 'h0201);
      check("stall_rd",     32'(mem_rd), 0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("resume_valid", 32'(instr_valid), 0);
    check("resume_addr",  32'(mem_addr), 'h0201);
    check("resume_rd",    32'(mem_rd), 1);

    // LDA #$42 ; STA $4000
    rst = 1'b1;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h40;
    tick();
    rst = 1'b0; instr_ready = 1'b1;
    wait_valid(n1);
    check("lda_lat",    32'(n1), 2);
    check("lda_opcode", 32'(opcode), 'hA9);
    check("lda_len",    32'(instr_len), 2);
    check("lda_lo",     32'(operand_lo), 'h42);
    check("lda_hi",     32'(operand_hi), 0);
    check("lda_ipc",    32'(instr_pc), 'h0200);
    mem[16'h0205] = 8'h4C; mem[16'h0206] = 8'h34; mem[16'h0207] = 8'h12;
    tick();
    wait_valid(n2);
    check("sta_lat",    32'(n1 + 1 + n2), 6);
    check("sta_opcode", 32'(opcode), 'h8D);
    check("sta_len",    32'(instr_len), 3);
    check("sta_lo",     32'(operand_lo), 0);
    check("sta_hi",     32'(operand_hi), 'h40);
    check("sta_ipc",    32'(instr_pc), 'h0202);

    // Redirect during FETCH_LO of JMP
    tick();
    check("jmp_op_addr", 32'(mem_addr), 'h0205);
    tick();
    check("jmp_lo_addr", 32'(mem_addr), 'h0206);
    pc_load = 1'b1; pc_new = 16'hC000;
    tick();
    pc_load = 1'b0;
    check("redir_valid", 32'(instr_valid), 0);
    check("redir_addr",  32'(mem_addr), 'hC000);
    tick();
    check("redir_b_valid", 32'(instr_valid), 1);
    check("redir_b_op",    32'(opcode), 'hEA);
    check("redir_b_ipc",   32'(instr_pc), 'hC000);

    // JSR straddling the address wrap
    rst = 1'b1; instr_ready = 1'b0;
    mem[16'hFFFF] = 8'h20; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB;
    mem[16'h0002] = 8'h4C;
    tick();
    rst = 1'b0; pc_load = 1'b1; pc_new = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    check("wrap_op_addr", 32'(mem_addr), 'hFFFF);
    tick();
    check("wrap_lo_addr", 32'(mem_addr), 'h0000);
    tick();
    check("wrap_hi_addr", 32'(mem_addr), 'h0001);
    tick();
    check("wrap_valid",  32'(instr_valid), 1);
    check("wrap_opcode", 32'(opcode), 'h20);
    check("wrap_len",    32'(instr_len), 3);
    check("wrap_lo",     32'(operand_lo), 'hCD);
    check("wrap_hi",     32'(operand_hi), 'hAB);
    check("wrap_ipc",    32'(instr_pc), 'hFFFF);
    check("wrap_next",   32'(mem_addr), 'h0002);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_fetch_addr", 32'(mem_addr), 'h0002);
    check("wrap_fetch_rd",   32'(mem_rd), 1);

    // Reset beats redirect while in FETCH_HI
    tick(); tick();
    check("hi_addr", 32'(mem_addr), 'h0004);
    rst = 1'b1; pc_load = 1'b1; pc_new = 16'h1234;
    tick();
    check("rstpl_addr",  32'(mem_addr), 'h0200);
    check("rstpl_valid", 32'(instr_valid), 0);
    check("rstpl_rd",    32'(mem_rd), 1);
`ifdef FETCH_SYNC_EN
    check("rstpl_sync",  32'(sync), 0);
`endif
    rst = 1'b0; pc_load = 1'b0;
    #1;
`ifdef FETCH_SYNC_EN
    check("sync_pulse", 32'(sync), 1);
`endif

    // Redirect and ready together in HOLD: redirect wins
    tick(); tick();
    check("pr_hold_valid", 32'(instr_valid), 1);
    check("pr_hold_op",    32'(opcode), 'hA9);
    instr_ready = 1'b1; pc_load = 1'b1; pc_new = 16'h3000;
    tick();
    instr_ready = 1'b0; pc_load = 1'b0;
    check("pr_addr",  32'(mem_addr), 'h3000);
    check("pr_valid", 32'(instr_valid), 0);
`ifdef FETCH_SYNC_EN
    check("pr_sync",  32'(sync), 1);
`endif

    // Length table spot checks
    for (int i = 0; i < 20; i++) begin
      check($sformatf("len_%02h", lv[i].op), 32'(instr_length(lv[i].op)), 32'(lv[i].len));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
